// File: rtl/i2c_mem_slave_if.sv
// Status/handshake bundle for the I2C memory target: transaction flags and last written byte.
interface i2c_mem_slave_if;
    logic       busy;
    logic       done;
    logic       wrStb;
    logic [7:0] dout;

    modport slave  (output busy, done, wrStb, dout);
    modport master (input  busy, done, wrStb, dout);
endinterface

// File: rtl/i2c_mem_slave.sv
// I2C target with internal byte memory: EEPROM-style pointer write, data write and
// sequential read with an auto-incrementing, wrapping pointer. Open-drain sda only.
module i2c_mem_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned MEM_DEPTH  = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           scl,
    inout  wire            sda,
    i2c_mem_slave_if.slave bus
);
    localparam int unsigned PW = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, DATA_ACK, WR_DATA, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t        state, state_n;
    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    shreg, shreg_n, byte_in, rd_byte;
    logic [PW-1:0] ptr, ptr_n;
    logic          sda_oe, sda_oe_n;
    logic          busy, busy_n;
    logic          phase, phase_n;
    logic          rw, rw_n;
    logic          done, done_n;
    logic          wr_stb, wr_stb_n;
    logic          mem_we;
    logic [7:0]    dout, dout_n;
    logic [7:0]    mem [MEM_DEPTH];

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.wrStb = wr_stb;
    assign bus.dout  = dout;

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;
    assign byte_in   = {shreg[6:0], sda_s2};
    assign rd_byte   = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
            cnt    <= '0;
            shreg  <= '0;
            ptr    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            phase  <= 1'b0;
            rw     <= 1'b0;
            done   <= 1'b0;
            wr_stb <= 1'b0;
            dout   <= '0;
        end else begin
            state  <= state_n;
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            ptr    <= ptr_n;
            sda_oe <= sda_oe_n;
            busy   <= busy_n;
            phase  <= phase_n;
            rw     <= rw_n;
            done   <= done_n;
            wr_stb <= wr_stb_n;
            dout   <= dout_n;
        end
    end

    // Memory is not reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr] <= byte_in;
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        ptr_n    = ptr;
        sda_oe_n = sda_oe;
        busy_n   = busy;
        phase_n  = phase;
        rw_n     = rw;
        done_n   = 1'b0;
        wr_stb_n = 1'b0;
        dout_n   = dout;
        mem_we   = 1'b0;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            phase_n  = 1'b0;
            done_n   = busy;
        end else if (start_det) begin
            state_n  = ADDR;
            cnt_n    = '0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
            phase_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        phase_n = 1'b0;
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            state_n = ADDR_ACK;
                            rw_n    = byte_in[0];
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                // phase 0: first scl fall starts the ACK; phase 1: next fall ends it
                ADDR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n = 1'b1;
                        busy_n   = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        phase_n  = 1'b0;
                        cnt_n    = '0;
                        sda_oe_n = 1'b0;
                        if (!rw) begin
                            state_n = PTR;
                        end else begin
                            state_n  = RD_DATA;
                            shreg_n  = rd_byte;
                            ptr_n    = ptr + 1'b1;
                            sda_oe_n = ~rd_byte[7];
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ptr_n   = byte_in[PW-1:0];
                        phase_n = 1'b0;
                        state_n = DATA_ACK;
                    end
                end
                DATA_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        cnt_n    = '0;
                        state_n  = WR_DATA;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        mem_we   = 1'b1;
                        dout_n   = byte_in;
                        wr_stb_n = 1'b1;
                        ptr_n    = ptr + 1'b1;
                        phase_n  = 1'b0;
                        state_n  = DATA_ACK;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (cnt == 3'd7) begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        cnt_n    = '0;
                        state_n  = RD_ACK;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                        cnt_n    = cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (!phase && scl_rise) begin
                        if (sda_s2) state_n = WAIT_STOP;
                        else        phase_n = 1'b1;
                    end else if (phase && scl_fall) begin
                        phase_n  = 1'b0;
                        cnt_n    = '0;
                        shreg_n  = rd_byte;
                        ptr_n    = ptr + 1'b1;
                        sda_oe_n = ~rd_byte[7];
                        state_n  = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bus-level bench for i2c_mem_slave: a bit-banged I2C master with write/read scoreboards.
module tb_i2c_mem_slave;
    localparam int unsigned Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_mem_slave_if bus ();

    i2c_mem_slave #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned done_cnt = 0;
    int unsigned wrstb_cnt = 0;
    int unsigned slave_low_cnt = 0;
    logic [7:0]  exp_wr[$];
    logic [7:0]  exp_rd[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and the write scoreboard are sampled on the falling clock edge.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (sda === 1'b0 && !m_sda_low) slave_low_cnt++;
        if (bus.wrStb) begin
            wrstb_cnt++;
            if (exp_wr.size() == 0) check("wr_unexpected", {24'd0, bus.dout}, 32'h100);
            else                    check("wr_dout", {24'd0, bus.dout}, {24'd0, exp_wr.pop_front()});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        b = sda;
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        check(tag, {31'd0, ~a}, {31'd0, exp_ack});
    endtask

    task automatic recv_byte(input logic nack, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        logic       b;
        exp_rd.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
        check(tag, {24'd0, d}, {24'd0, exp_rd.pop_front()});
    endtask

    task automatic write_data(input logic [7:0] b, input string tag);
        exp_wr.push_back(b);
        send_byte(b, 1'b1, tag);
    endtask

    int unsigned d0, w0, s0;

    initial begin
        tick(5);
        rst = 1'b0;
        tick(5);
        check("rst_busy",  {31'd0, bus.busy},  0);
        check("rst_done",  {31'd0, bus.done},  0);
        check("rst_wrstb", {31'd0, bus.wrStb}, 0);
        check("rst_dout",  {24'd0, bus.dout},  0);
        check("rst_sda",   {31'd0, sda},       1);
        check("rst_ptr",   {25'd0, dut.ptr},   0);

        // single-byte write
        d0 = done_cnt; w0 = wrstb_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1, "w_addr_ack");
        check("w_busy", {31'd0, bus.busy}, 1);
        send_byte(8'h05, 1'b1, "w_ptr_ack");
        write_data(8'h3C, "w_data_ack");
        i2c_stop();
        tick(4);
        check("w_mem5",     {24'd0, dut.mem[5]}, 32'h3C);
        check("w_wrstb",    wrstb_cnt - w0, 1);
        check("w_done",     done_cnt - d0, 1);
        check("w_busy_end", {31'd0, bus.busy}, 0);
        check("w_dout",     {24'd0, bus.dout}, 32'h3C);

        // pointer set, repeated START, single read with NACK
        d0 = done_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1, "r_addr_w_ack");
        send_byte(8'h05, 1'b1, "r_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b1, "r_addr_r_ack");
        recv_byte(1'b1, 8'h3C, "r_byte");
        i2c_stop();
        tick(4);
        check("r_ptr",  {25'd0, dut.ptr}, 6);
        check("r_done", done_cnt - d0, 1);

        // burst write and read across the pointer wrap
        i2c_start();
        send_byte(8'hA0, 1'b1, "bw_addr_ack");
        send_byte(8'h7F, 1'b1, "bw_ptr_ack");
        write_data(8'h11, "bw_d0_ack");
        write_data(8'h22, "bw_d1_ack");
        i2c_stop();
        tick(4);
        check("bw_mem127", {24'd0, dut.mem[127]}, 32'h11);
        check("bw_mem0",   {24'd0, dut.mem[0]},   32'h22);
        check("bw_ptr",    {25'd0, dut.ptr},      1);
        i2c_start();
        send_byte(8'hA0, 1'b1, "br_addr_w_ack");
        send_byte(8'h7F, 1'b1, "br_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b1, "br_addr_r_ack");
        recv_byte(1'b0, 8'h11, "br_byte0");
        recv_byte(1'b1, 8'h22, "br_byte1");
        i2c_stop();
        tick(4);

        // address miss
        d0 = done_cnt; w0 = wrstb_cnt; s0 = slave_low_cnt;
        i2c_start();
        send_byte(8'h90, 1'b0, "m_addr_nack");
        send_byte(8'h55, 1'b0, "m_data_nack");
        i2c_stop();
        tick(4);
        check("m_sda_never_low", slave_low_cnt - s0, 0);
        check("m_busy",  {31'd0, bus.busy}, 0);
        check("m_wrstb", wrstb_cnt - w0, 0);
        check("m_done",  done_cnt - d0, 0);

        // partial byte aborted by STOP
        i2c_start();
        send_byte(8'hA0, 1'b1, "a_pre_addr_ack");
        send_byte(8'h10, 1'b1, "a_pre_ptr_ack");
        write_data(8'h5A, "a_pre_data_ack");
        i2c_stop();
        d0 = done_cnt; w0 = wrstb_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1, "a_addr_ack");
        send_byte(8'h10, 1'b1, "a_ptr_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        tick(4);
        check("a_done",  done_cnt - d0, 1);
        check("a_wrstb", wrstb_cnt - w0, 0);
        check("a_busy",  {31'd0, bus.busy}, 0);
        check("a_ptr",   {25'd0, dut.ptr}, 32'h10);
        i2c_start();
        send_byte(8'hA0, 1'b1, "a_rb_addr_w_ack");
        send_byte(8'h10, 1'b1, "a_rb_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b1, "a_rb_addr_r_ack");
        recv_byte(1'b1, 8'h5A, "a_rb_byte");
        i2c_stop();

        // rst while the target drives a 0 data bit (mem[0]=0x22, MSB 0)
        i2c_start();
        send_byte(8'hA0, 1'b1, "rr_addr_w_ack");
        send_byte(8'h00, 1'b1, "rr_ptr_ack");
        i2c_start();
        send_byte(8'hA1, 1'b1, "rr_addr_r_ack");
        check("rr_sda_driven", {31'd0, sda}, 0);
        rst = 1'b1;
        tick(1);
        check("rr_sda_released", {31'd0, sda}, 1);
        rst = 1'b0;
        check("rr_busy", {31'd0, bus.busy}, 0);
        check("rr_ptr",  {25'd0, dut.ptr}, 0);
        i2c_stop();
        tick(4);
        i2c_start();
        send_byte(8'hA1, 1'b1, "rr_rb_addr_ack");
        recv_byte(1'b1, 8'h22, "rr_rb_byte");
        i2c_stop();
        tick(4);
        check("rr_rb_ptr", {25'd0, dut.ptr}, 1);

        check("wr_queue_empty", exp_wr.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
